adder_sum_accumulator: RTL and testbench
========================================

Name: adder_sum_accumulator

Overview:
- Downstream stage of the registered adder; it consumes each `sum` word the adder produces.
- Accumulates BLOCK_LEN consecutive sums into a full-precision block total.
- Presents the total on a valid/ready output register.
- Applies backpressure to the adder side only when a finished total cannot yet be handed off.

Parameters:
- ADDER_WIDTH, 17, operand width of the upstream adder.
- BLOCK_LEN, 8, number of sums per block. Legal range is BLOCK_LEN >= 2; elaboration error otherwise.
- SUM_W (localparam), ADDER_WIDTH+1, width of one incoming sum.
- CNT_W (localparam), $clog2(BLOCK_LEN), width of the sample counter.
- ACC_W (localparam), SUM_W+$clog2(BLOCK_LEN), accumulator and result width. Overflow is impossible by construction.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush of the partial block.
- in_valid  in  1  in_sum is valid this cycle.
- in_sum  in  SUM_W  unsigned sum from the adder.
- in_ready  out  1  block accepts in_sum this cycle.
- out_valid  out  1  out_acc holds a completed block total.
- out_acc  out  ACC_W  unsigned block total.
- out_ready  in  1  consumer takes out_acc this cycle.

Behaviour:
- Reset (reset_n=0, asynchronous): acc=0, cnt=0, out_valid=0, out_acc=0. The reset may arrive mid-block or while out_valid=1; the partial block and any pending result are discarded.
- Transfer rules:
  - accept = in_valid & in_ready.
  - handoff = out_valid & out_ready.
- Last-sample condition: last = (cnt == BLOCK_LEN-1).
- in_ready (combinational) = !clear & !(last & out_valid & !out_ready).
  - Non-final samples are always accepted while the output waits.
  - Only the sample that would complete a block stalls.
  - in_ready may depend on out_ready in the same cycle; no register in this path.
- Accept with !last: acc <= acc + in_sum, cnt <= cnt+1.
- Accept with last:
  - out_acc <= acc + in_sum, out_valid <= 1.
  - acc <= 0, cnt <= 0.
- handoff with no completing accept: out_valid <= 0.
- handoff and completing accept in the same cycle: the new total is loaded, out_valid stays 1, and no bubble is inserted.
- Latency: out_valid rises on the edge that accepts the BLOCK_LEN-th sample, so it is visible the cycle after that accept.
- Throughput: one total every BLOCK_LEN accepted samples at full rate when out_ready=1.
- clear=1:
  - acc <= 0, cnt <= 0.
  - in_ready=0, so any in_sum offered that cycle is not consumed.
  - The pending out_valid/out_acc is untouched, and a handoff in that cycle still completes.
- in_valid=0 cycles: no state change other than handoff. Idle gaps do not affect the totals.
- out_acc is stable while out_valid=1 & !out_ready.
- All arithmetic is unsigned. in_sum is zero-extended to ACC_W before addition.

Decomposition:
- Shared package adder_pkg holds:
  - ADDER_WIDTH default.
  - Functions sum_width(aw)=aw+1 and acc_width(aw,n)=aw+1+$clog2(n), reused by the adder and this block.
- No sub-module is needed. Counter, accumulator and output register live in one module, with no FSM beyond cnt/out_valid.

Test Plan:
- BLOCK_LEN=8, out_ready=1, in_sum=1..8 back-to-back -> single-cycle out_valid pulse with out_acc=36, one cycle after the 8th accept.
- 8 samples of 262143 (max 18-bit) -> out_acc=2097144 (21 bits), no truncation.
- out_ready=0 after the first block (36); feed 8 samples of 2:
  - 7 are accepted and in_ready drops with the 8th held.
  - Raise out_ready: 36 is handed off in that cycle, the 8th sample is accepted in the same cycle, and out_acc=16 the next cycle with out_valid continuously 1.
- 3 samples of 9, then clear together with in_valid=1/in_sum=7, then 8 samples of 5 -> in_ready=0 during clear, 7 is not taken, out_acc=40.
- reset_n pulsed low asynchronously with out_valid=1 and cnt=5 -> out_valid/out_acc drop to 0 immediately; after release, 8 samples of 3 give out_acc=24.
- Random in_valid gaps with in_sum=10 across 8 accepts -> out_acc=80, unaffected by idle cycles.

Source files
------------

// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the registered adder and its downstream stages.
// Holds the default operand width and the width helpers, so the adder and
// the sum accumulator size their buses from the same formulas.
// No ports (package).
// -----------------------------------------------------------------------------
package adder_pkg;

   // Default operand width of the upstream adder.
   localparam int ADDER_WIDTH_DEFAULT = 17;

   // Width of one adder result: the operands plus one carry bit.
   function automatic int sum_width(input int aw);
      return aw + 1;
   endfunction

   // Width that holds n summed adder results with no possible overflow.
   function automatic int acc_width(input int aw, input int n);
      return aw + 1 + $clog2(n);
   endfunction

endpackage : adder_pkg

// File: rtl/adder_sum_accumulator.sv
// -----------------------------------------------------------------------------
// adder_sum_accumulator
// Sums BLOCK_LEN consecutive adder results into a full-precision block total.
// The total is presented on a valid/ready output register. Upstream
// backpressure is applied only to the sample that would complete a block
// while the previous total is still waiting.
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset_n    in   1      asynchronous active-low reset
//   clear      in   1      synchronous flush of the partial block
//   in_valid   in   1      in_sum is valid this cycle
//   in_sum     in   SUM_W  unsigned sum from the adder
//   in_ready   out  1      in_sum is accepted this cycle (combinational)
//   out_valid  out  1      out_acc holds a completed block total
//   out_acc    out  ACC_W  unsigned block total
//   out_ready  in   1      consumer takes out_acc this cycle
// -----------------------------------------------------------------------------
module adder_sum_accumulator
   import adder_pkg::*;
#(
   parameter int ADDER_WIDTH = ADDER_WIDTH_DEFAULT,
   parameter int BLOCK_LEN   = 8,
   localparam int SUM_W      = sum_width(ADDER_WIDTH),
   localparam int CNT_W      = $clog2(BLOCK_LEN),
   localparam int ACC_W      = acc_width(ADDER_WIDTH, BLOCK_LEN)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [SUM_W-1:0] in_sum,
   output logic             in_ready,
   output logic             out_valid,
   output logic [ACC_W-1:0] out_acc,
   input  logic             out_ready
);

   // A block of fewer than two samples makes the counter zero bits wide.
   if (BLOCK_LEN < 2) begin : g_block_len_check
      $error("adder_sum_accumulator: BLOCK_LEN must be >= 2");
   end

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

   logic [ACC_W-1:0] acc_r;
   logic [CNT_W-1:0] cnt_r;
   logic             out_valid_r;
   logic [ACC_W-1:0] out_acc_r;

   logic [ACC_W-1:0] acc_nxt_s;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             out_valid_nxt_s;
   logic [ACC_W-1:0] out_acc_nxt_s;

   logic             last_s;
   logic             accept_s;
   logic             handoff_s;
   logic [ACC_W-1:0] sum_ext_s;
   logic [ACC_W-1:0] acc_sum_s;

   assign last_s    = (cnt_r == LAST_CNT);
   // Only the completing sample stalls, and only if the held total cannot
   // leave this very cycle; out_ready feeds straight through to in_ready.
   assign in_ready  = !clear && !(last_s && out_valid_r && !out_ready);
   assign accept_s  = in_valid && in_ready;
   assign handoff_s = out_valid_r && out_ready;
   assign sum_ext_s = {{(ACC_W-SUM_W){1'b0}}, in_sum};
   assign acc_sum_s = acc_r + sum_ext_s;

   assign out_valid = out_valid_r;
   assign out_acc   = out_acc_r;

   // Next-state logic for the partial sum, sample counter and output register.
   always_comb begin
      acc_nxt_s       = acc_r;
      cnt_nxt_s       = cnt_r;
      out_valid_nxt_s = out_valid_r;
      out_acc_nxt_s   = out_acc_r;

      if (handoff_s) begin
         out_valid_nxt_s = 1'b0;
      end else begin
         out_valid_nxt_s = out_valid_r;
      end

      if (clear) begin
         acc_nxt_s = {ACC_W{1'b0}};
         cnt_nxt_s = {CNT_W{1'b0}};
      end else if (accept_s) begin
         if (last_s) begin
            // A completing accept overrides a same-cycle handoff, so the
            // next total follows the previous one without a bubble.
            out_acc_nxt_s   = acc_sum_s;
            out_valid_nxt_s = 1'b1;
            acc_nxt_s       = {ACC_W{1'b0}};
            cnt_nxt_s       = {CNT_W{1'b0}};
         end else begin
            acc_nxt_s = acc_sum_s;
            cnt_nxt_s = cnt_r + CNT_W'(1);
         end
      end else begin
         acc_nxt_s = acc_r;
         cnt_nxt_s = cnt_r;
      end
   end

   // State registers; reset discards any partial block and pending total.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_r       <= {ACC_W{1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
         out_valid_r <= 1'b0;
         out_acc_r   <= {ACC_W{1'b0}};
      end else begin
         acc_r       <= acc_nxt_s;
         cnt_r       <= cnt_nxt_s;
         out_valid_r <= out_valid_nxt_s;
         out_acc_r   <= out_acc_nxt_s;
      end
   end

endmodule : adder_sum_accumulator

// File: tb/tb_adder_sum_accumulator.sv
// -----------------------------------------------------------------------------
// tb_adder_sum_accumulator
// Directed self-checking bench for adder_sum_accumulator (ADDER_WIDTH=17,
// BLOCK_LEN=8). Inputs change 1 ns after each rising edge; outputs are
// checked at that point as well.
// -----------------------------------------------------------------------------
module tb_adder_sum_accumulator;

   localparam int SUM_W = 18;
   localparam int ACC_W = 21;

   logic             clk;
   logic             reset_n;
   logic             clear;
   logic             in_valid;
   logic [SUM_W-1:0] in_sum;
   logic             in_ready;
   logic             out_valid;
   logic [ACC_W-1:0] out_acc;
   logic             out_ready;

   int n_checks;
   int n_fail;

   adder_sum_accumulator #(
      .ADDER_WIDTH(17),
      .BLOCK_LEN  (8)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (clear),
      .in_valid (in_valid),
      .in_sum   (in_sum),
      .in_ready (in_ready),
      .out_valid(out_valid),
      .out_acc  (out_acc),
      .out_ready(out_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] observed,
                      input logic [31:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Advance one rising edge and settle 1 ns past it.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Offer one sample for exactly one edge.
   task automatic feed(input logic [SUM_W-1:0] v);
      in_valid = 1'b1;
      in_sum   = v;
      cycle();
      in_valid = 1'b0;
      in_sum   = '0;
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      reset_n   = 1'b0;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_sum    = '0;
      out_ready = 1'b1;

      // Reset state
      cycle();
      cycle();
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_out_acc", 32'(out_acc), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      reset_n = 1'b1;
      cycle();

      // Block 1..8 -> 36, single-cycle pulse
      for (int i = 1; i <= 7; i++) feed(SUM_W'(i));
      chk("b1_no_early_valid", 32'(out_valid), 32'd0);
      feed(18'd8);
      chk("b1_valid", 32'(out_valid), 32'd1);
      chk("b1_acc", 32'(out_acc), 32'd36);
      cycle();
      chk("b1_pulse_drop", 32'(out_valid), 32'd0);

      // Max-value samples -> no truncation
      for (int i = 0; i < 8; i++) feed(18'd262143);
      chk("max_valid", 32'(out_valid), 32'd1);
      chk("max_acc", 32'(out_acc), 32'd2097144);
      cycle();
      chk("max_drop", 32'(out_valid), 32'd0);

      // Backpressure: 36 held, 7 samples of 2 accepted, 8th stalls
      for (int i = 1; i <= 8; i++) feed(SUM_W'(i));
      out_ready = 1'b0;
      chk("bp_first_acc", 32'(out_acc), 32'd36);
      for (int i = 0; i < 7; i++) feed(18'd2);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_acc", 32'(out_acc), 32'd36);
      in_valid = 1'b1;
      in_sum   = 18'd2;
      #1;
      chk("bp_stall_ready", 32'(in_ready), 32'd0);
      cycle();
      chk("bp_stall_valid", 32'(out_valid), 32'd1);
      chk("bp_stall_acc", 32'(out_acc), 32'd36);
      chk("bp_stall_ready2", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(in_ready), 32'd1);
      cycle();
      in_valid = 1'b0;
      in_sum   = '0;
      chk("bp_no_bubble_valid", 32'(out_valid), 32'd1);
      chk("bp_new_acc", 32'(out_acc), 32'd16);
      cycle();
      chk("bp_drop", 32'(out_valid), 32'd0);

      // Clear mid-block; the sample offered during clear is not taken
      for (int i = 0; i < 3; i++) feed(18'd9);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_sum   = 18'd7;
      #1;
      chk("clear_ready", 32'(in_ready), 32'd0);
      cycle();
      clear    = 1'b0;
      in_valid = 1'b0;
      in_sum   = '0;
      chk("clear_no_valid", 32'(out_valid), 32'd0);
      for (int i = 0; i < 8; i++) feed(18'd5);
      chk("clear_valid", 32'(out_valid), 32'd1);
      chk("clear_acc", 32'(out_acc), 32'd40);
      cycle();

      // Asynchronous reset while out_valid=1 and cnt=5
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) feed(18'd1);
      for (int i = 0; i < 5; i++) feed(18'd1);
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      chk("pre_rst_acc", 32'(out_acc), 32'd8);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_acc", 32'(out_acc), 32'd0);
      cycle();
      reset_n   = 1'b1;
      out_ready = 1'b1;
      cycle();
      for (int i = 0; i < 7; i++) feed(18'd3);
      chk("post_rst_no_valid", 32'(out_valid), 32'd0);
      feed(18'd3);
      chk("post_rst_valid", 32'(out_valid), 32'd1);
      chk("post_rst_acc", 32'(out_acc), 32'd24);
      cycle();

      // Idle gaps between accepts do not affect the total
      begin
         int gaps[8] = '{0, 2, 1, 0, 3, 1, 0, 2};
         for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < gaps[i]; g++) cycle();
            feed(18'd10);
            if (i < 7) chk("gap_no_valid", 32'(out_valid), 32'd0);
         end
      end
      chk("gap_valid", 32'(out_valid), 32'd1);
      chk("gap_acc", 32'(out_acc), 32'd80);
      cycle();
      chk("gap_drop", 32'(out_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule : tb_adder_sum_accumulator
